// File: rtl/simple_uart_tx.sv
// UART transmit serializer: pops words from the transmit FIFO and sends
// start bit, LSB-first data, optional parity and 1 or 2 stop bits on txd.
module simple_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 434,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  txd,
  output logic                  busy
);

  localparam int BCNT_W  = $clog2(CLK_DIV);
  localparam int BIT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_q, par_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;

  logic bit_end;
  logic last_data;
  logic last_stop;
  logic load;
  logic par_bit;

  always_comb begin
    bit_end   = (bcnt_q == BCNT_W'(CLK_DIV - 1));
    last_data = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
    last_stop = (bit_cnt_q == BIT_W'(STOP_BITS - 1));
    par_bit   = (PARITY == 2) ? par_q : ~par_q;
    load      = ~RST & ~fifo_empty &
                ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end & last_stop));

    state_d   = state_q;
    bcnt_d    = bit_end ? '0 : bcnt_q + BCNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    txd_d     = txd_q;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          txd_d     = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (last_data) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              txd_d   = par_bit;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d   = S_STOP;
          txd_d     = 1'b1;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            txd_d     = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A pop always starts a fresh frame, including straight out of the last stop bit
    if (load) begin
      shreg_d   = fifo_rd_data;
      par_d     = ^fifo_rd_data;
      state_d   = S_START;
      bcnt_d    = '0;
      bit_cnt_d = '0;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  assign fifo_rd_en = load;
  assign txd        = txd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_simple_uart_tx.sv
// Directed bench for simple_uart_tx: four instances cover no parity, even,
// odd and two stop bits, each fed by a small behavioural FIFO.
module tb_simple_uart_tx;

  localparam int CLKD = 4;

  logic       CLK;
  logic       RST;
  logic [3:0] empty_w;
  logic [3:0] rd_en_w;
  logic [3:0] txd_w;
  logic [3:0] busy_w;
  logic [7:0] rd_data [4];

  logic [7:0] mem  [4][16];
  logic [3:0] wptr [4];
  logic [3:0] rptr [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  int cyc = 0;
  int pop_cnt [4] = '{0, 0, 0, 0};
  int bad_pop [4] = '{0, 0, 0, 0};
  int pop_cyc [4][8];
  logic [3:0] prev_rd = 4'b0000;

  int checks;
  int errors;

  logic [15:0] bits;
  int          bc;
  int          bc_sum;
  int          anomalies;

  simple_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(CLKD), .PARITY(0), .STOP_BITS(1)) u_base (
    .CLK(CLK), .RST(RST), .fifo_rd_data(rd_data[0]), .fifo_empty(empty_w[0]),
    .fifo_rd_en(rd_en_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));

  simple_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(CLKD), .PARITY(2), .STOP_BITS(1)) u_even (
    .CLK(CLK), .RST(RST), .fifo_rd_data(rd_data[1]), .fifo_empty(empty_w[1]),
    .fifo_rd_en(rd_en_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));

  simple_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(CLKD), .PARITY(1), .STOP_BITS(1)) u_odd (
    .CLK(CLK), .RST(RST), .fifo_rd_data(rd_data[2]), .fifo_empty(empty_w[2]),
    .fifo_rd_en(rd_en_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));

  simple_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(CLKD), .PARITY(0), .STOP_BITS(2)) u_two (
    .CLK(CLK), .RST(RST), .fifo_rd_data(rd_data[3]), .fifo_empty(empty_w[3]),
    .fifo_rd_en(rd_en_w[3]), .txd(txd_w[3]), .busy(busy_w[3]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar c = 0; c < 4; c++) begin : g_fifo
    assign empty_w[c] = (wptr[c] == rptr[c]);
    assign rd_data[c] = mem[c][rptr[c]];
  end

  // FIFO read side plus pop bookkeeping: when, how often, and illegal pops
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 4; c++) begin
      if (rd_en_w[c]) begin
        if ((wptr[c] == rptr[c]) || prev_rd[c]) bad_pop[c] <= bad_pop[c] + 1;
        rptr[c] <= rptr[c] + 4'd1;
        pop_cyc[c][pop_cnt[c] % 8] <= cyc;
        pop_cnt[c] <= pop_cnt[c] + 1;
      end
      prev_rd[c] <= rd_en_w[c];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [7:0] d);
    mem[ch][wptr[ch]] = d;
    wptr[ch] = wptr[ch] + 4'd1;
  endtask

  // Starts sampling at the current falling edge; leaves off ncyc edges later
  task automatic sampleFrame(input int ch, input int ncyc,
                             output logic [15:0] fbits, output int busy_cnt);
    fbits    = '0;
    busy_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (busy_w[ch]) busy_cnt++;
      if ((i % CLKD) == 1) fbits[i / CLKD] = txd_w[ch];
      @(negedge CLK);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    for (int c = 0; c < 4; c++) wptr[c] = 4'd0;

    applyStimulus(0, 8'h55);
    repeat (5) begin
      @(negedge CLK);
      checkOutput("rst_txd", txd_w[0], 1);
      checkOutput("rst_busy", busy_w[0], 0);
      checkOutput("rst_rd_en", rd_en_w[0], 0);
    end

    RST = 1'b0;
    #1;
    checkOutput("rel_pop_strobe", rd_en_w[0], 1);
    @(negedge CLK);
    checkOutput("rel_pop_cnt", pop_cnt[0], 1);
    checkOutput("rel_rd_en_low", rd_en_w[0], 0);

    sampleFrame(0, 40, bits, bc);
    checkOutput("base_bits_55", bits, 16'h02AA);
    checkOutput("base_busy_cycles", bc, 40);
    checkOutput("base_idle_busy", busy_w[0], 0);
    checkOutput("base_idle_txd", txd_w[0], 1);
    checkOutput("base_one_pop", pop_cnt[0], 1);

    applyStimulus(1, 8'h55);
    @(negedge CLK);
    sampleFrame(1, 44, bits, bc);
    checkOutput("even_bits_55", bits, 16'h04AA);
    checkOutput("even_par_55", bits[9], 0);
    checkOutput("even_busy_cycles", bc, 44);
    checkOutput("even_idle_busy", busy_w[1], 0);

    applyStimulus(1, 8'h80);
    @(negedge CLK);
    sampleFrame(1, 44, bits, bc);
    checkOutput("even_bits_80", bits, 16'h0700);
    checkOutput("even_par_80", bits[9], 1);

    applyStimulus(2, 8'h55);
    @(negedge CLK);
    sampleFrame(2, 44, bits, bc);
    checkOutput("odd_bits_55", bits, 16'h06AA);
    checkOutput("odd_par_55", bits[9], 1);
    checkOutput("odd_busy_cycles", bc, 44);

    applyStimulus(3, 8'hA5);
    applyStimulus(3, 8'h3C);
    applyStimulus(3, 8'hFF);
    @(negedge CLK);
    sampleFrame(3, 44, bits, bc);
    checkOutput("b2b_bits_a5", bits, 16'h074A);
    bc_sum = bc;
    sampleFrame(3, 44, bits, bc);
    checkOutput("b2b_bits_3c", bits, 16'h0678);
    bc_sum += bc;
    sampleFrame(3, 44, bits, bc);
    checkOutput("b2b_bits_ff", bits, 16'h07FE);
    bc_sum += bc;
    checkOutput("b2b_busy_cycles", bc_sum, 132);
    checkOutput("b2b_pop_cnt", pop_cnt[3], 3);
    checkOutput("b2b_gap_1", pop_cyc[3][1] - pop_cyc[3][0], 44);
    checkOutput("b2b_gap_2", pop_cyc[3][2] - pop_cyc[3][0], 88);
    checkOutput("b2b_idle_busy", busy_w[3], 0);
    checkOutput("b2b_idle_txd", txd_w[3], 1);

    applyStimulus(0, 8'h33);
    @(negedge CLK);
    sampleFrame(0, 39, bits, bc);
    checkOutput("late_busy_in_stop", busy_w[0], 1);
    checkOutput("late_txd_in_stop", txd_w[0], 1);
    applyStimulus(0, 8'h01);
    #1;
    checkOutput("late_pop_strobe", rd_en_w[0], 1);
    @(negedge CLK);
    checkOutput("late_pop_gap", pop_cyc[0][2] - pop_cyc[0][1], 40);
    checkOutput("late_busy_kept", busy_w[0], 1);
    sampleFrame(0, 40, bits, bc);
    checkOutput("late_bits_01", bits, 16'h0202);
    checkOutput("late_busy_cycles", bc, 40);
    checkOutput("late_idle_busy", busy_w[0], 0);

    repeat (3) @(negedge CLK);
    applyStimulus(0, 8'hF0);
    #1;
    checkOutput("idlew_pop_strobe", rd_en_w[0], 1);
    checkOutput("idlew_txd_still_high", txd_w[0], 1);
    @(negedge CLK);
    checkOutput("idlew_start_bit", txd_w[0], 0);
    sampleFrame(0, 40, bits, bc);
    checkOutput("idlew_bits_f0", bits, 16'h03E0);
    checkOutput("idlew_busy_cycles", bc, 40);

    applyStimulus(0, 8'h00);
    @(negedge CLK);
    repeat (17) @(negedge CLK);
    checkOutput("midrst_data3_txd", txd_w[0], 0);
    checkOutput("midrst_data3_busy", busy_w[0], 1);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("midrst_txd", txd_w[0], 1);
    checkOutput("midrst_busy", busy_w[0], 0);
    checkOutput("midrst_rd_en", rd_en_w[0], 0);
    RST = 1'b0;
    anomalies = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((txd_w[0] !== 1'b1) || (busy_w[0] !== 1'b0) || (rd_en_w[0] !== 1'b0)) anomalies++;
    end
    checkOutput("midrst_stays_idle", anomalies, 0);
    checkOutput("midrst_no_repop", pop_cnt[0], 5);

    checkOutput("no_bad_pops", bad_pop[0] + bad_pop[1] + bad_pop[2] + bad_pop[3], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
